// File: rtl/raster_compositor_pkg.sv
// raster_compositor_pkg
// Shared color definitions for the paint display: the layer color codes,
// the 24-bit RGB palette and the code-to-RGB lookup used by the compositor.
package raster_compositor_pkg;

   localparam int COLOR_WIDTH = 3;

   localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 3'd0;
   localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 3'd1;
   localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 3'd2;
   localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 3'd3;
   localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 3'd4;
   localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 3'd5;

   localparam logic [23:0] RGB_BLACK = 24'h000000;
   localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
   localparam logic [23:0] RGB_RED   = 24'hFF0000;
   localparam logic [23:0] RGB_GREEN = 24'h00FF00;
   localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

   // NONE is only meaningful as "transparent" in the overlay; if it ever
   // reaches the palette it shows as black, as do unassigned codes.
   function automatic logic [23:0] color_to_rgb(input logic [COLOR_WIDTH-1:0] code);
      logic [23:0] rgb;
      case (code)
         COLOR_WHITE: rgb = RGB_WHITE;
         COLOR_RED:   rgb = RGB_RED;
         COLOR_GREEN: rgb = RGB_GREEN;
         COLOR_BLUE:  rgb = RGB_BLUE;
         default:     rgb = RGB_BLACK;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/raster_compositor_vga_timing.sv
// vga_timing
// Horizontal/vertical scan counters for a VGA-style frame. Advances one
// pixel per pix_en strobe and decodes active video and the raw syncs from
// the current counter values.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pix_en            pixel-advance strobe
//   h_cnt_o, v_cnt_o  current scan position
//   active_o          position is inside the visible area
//   hs_raw_o          horizontal sync, low during the sync interval
//   vs_raw_o          vertical sync, low during the sync interval
//   frame_start_o     one-clk pulse after the edge that wraps to (0,0)
module vga_timing #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int HW     = $clog2(WIDTH + H_FP + H_SYNC + H_BP),
   parameter int VW     = $clog2(HEIGHT + V_FP + V_SYNC + V_BP)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   output logic [HW-1:0] h_cnt_o,
   output logic [VW-1:0] v_cnt_o,
   output logic          active_o,
   output logic          hs_raw_o,
   output logic          vs_raw_o,
   output logic          frame_start_o
);

   localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(WIDTH);
   localparam logic [HW-1:0] HS_START = HW'(WIDTH + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(WIDTH + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(HEIGHT);
   localparam logic [VW-1:0] VS_START = VW'(HEIGHT + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(HEIGHT + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          frame_start_q, frame_start_d;

   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      frame_start_d = 1'b0;
      if (pix_en) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d       = '0;
               frame_start_d = 1'b1;
            end else begin
               v_cnt_d = v_cnt_q + VW'(1);
            end
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign h_cnt_o       = h_cnt_q;
   assign v_cnt_o       = v_cnt_q;
   assign active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign hs_raw_o      = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
   assign vs_raw_o      = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
   assign frame_start_o = frame_start_q;

endmodule

// File: rtl/raster_compositor.sv
// raster_compositor
// Raster-scan reader for the paint display. Requests each visible pixel from
// the cursor overlay and canvas stores, composites the returned codes (cursor
// wins unless NONE), maps through the palette and registers RGB, syncs and
// blanking together so they stay aligned.
// Optional build macro: COMPOSITOR_BORDER_EN draws a white 1-pixel frame
// around the visible area, overriding both layers.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   pix_en                       pixel-advance strobe
//   req_x, req_y                 position requested from both layers (0 when blanked)
//   cursor_color, canvas_color   layer data for the current request
//   vga_r, vga_g, vga_b          registered pixel color
//   vga_hs_n, vga_vs_n           registered syncs, active-low
//   vga_blank_n                  registered, high during active video
//   frame_start                  one-clk pulse when the scan wraps to (0,0)
module raster_compositor
   import raster_compositor_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pix_en,
   output logic [$clog2(WIDTH)-1:0]   req_x,
   output logic [$clog2(HEIGHT)-1:0]  req_y,
   input  logic [COLOR_WIDTH-1:0]     cursor_color,
   input  logic [COLOR_WIDTH-1:0]     canvas_color,
   output logic [7:0]                 vga_r,
   output logic [7:0]                 vga_g,
   output logic [7:0]                 vga_b,
   output logic                       vga_hs_n,
   output logic                       vga_vs_n,
   output logic                       vga_blank_n,
   output logic                       frame_start
);

   localparam int HW = $clog2(WIDTH + H_FP + H_SYNC + H_BP);
   localparam int VW = $clog2(HEIGHT + V_FP + V_SYNC + V_BP);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active;
   logic          hs_raw;
   logic          vs_raw;

   vga_timing #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .H_FP   (H_FP),
      .H_SYNC (H_SYNC),
      .H_BP   (H_BP),
      .V_FP   (V_FP),
      .V_SYNC (V_SYNC),
      .V_BP   (V_BP),
      .HW     (HW),
      .VW     (VW)
   ) u_timing (
      .clk           (clk),
      .reset         (reset),
      .pix_en        (pix_en),
      .h_cnt_o       (h_cnt),
      .v_cnt_o       (v_cnt),
      .active_o      (active),
      .hs_raw_o      (hs_raw),
      .vs_raw_o      (vs_raw),
      .frame_start_o (frame_start)
   );

   // Requests come straight off the counters so the stores see the new
   // position a full clk before the next strobe can consume the data.
   assign req_x = active ? XW'(h_cnt) : '0;
   assign req_y = active ? YW'(v_cnt) : '0;

   logic [COLOR_WIDTH-1:0] color_sel;
   logic [23:0]            pix_rgb;

`ifdef COMPOSITOR_BORDER_EN
   localparam logic [HW-1:0] X_LAST = HW'(WIDTH - 1);
   localparam logic [VW-1:0] Y_LAST = VW'(HEIGHT - 1);
   logic on_border;
   assign on_border = (h_cnt == '0) || (h_cnt == X_LAST) ||
                      (v_cnt == '0) || (v_cnt == Y_LAST);
`endif

   always_comb begin
      color_sel = (cursor_color != COLOR_NONE) ? cursor_color : canvas_color;
      pix_rgb   = color_to_rgb(color_sel);
`ifdef COMPOSITOR_BORDER_EN
      if (on_border) begin
         pix_rgb = RGB_WHITE;
      end
`endif
      if (!active) begin
         pix_rgb = RGB_BLACK;
      end
   end

   logic [23:0] rgb_q;
   logic        hs_n_q;
   logic        vs_n_q;
   logic        blank_n_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q     <= RGB_BLACK;
         hs_n_q    <= 1'b1;
         vs_n_q    <= 1'b1;
         blank_n_q <= 1'b0;
      end else if (pix_en) begin
         rgb_q     <= pix_rgb;
         hs_n_q    <= hs_raw;
         vs_n_q    <= vs_raw;
         blank_n_q <= active;
      end
   end

   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign vga_hs_n    = hs_n_q;
   assign vga_vs_n    = vs_n_q;
   assign vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_raster_compositor.sv
module tb_raster_compositor;
   import raster_compositor_pkg::*;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int HT = 14;
   localparam int VT = 10;
`ifdef COMPOSITOR_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       pix_en;
   logic [2:0] req_x;
   logic [1:0] req_y;
   logic [2:0] cursor_color;
   logic [2:0] canvas_color;
   logic [7:0] vga_r, vga_g, vga_b;
   logic       vga_hs_n, vga_vs_n, vga_blank_n, frame_start;

   raster_compositor #(
      .WIDTH(W), .HEIGHT(H),
      .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .req_x(req_x), .req_y(req_y),
      .cursor_color(cursor_color), .canvas_color(canvas_color),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n),
      .vga_blank_n(vga_blank_n), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: scan position plus the expected registered outputs.
   int          mh, mv;
   int          ph, pv;
   logic [23:0] e_rgb;
   logic        e_hs, e_vs, e_blank, e_fs;

   logic [2:0] canvas_map [0:H-1][0:W-1];
   logic [2:0] cursor_map [0:H-1][0:W-1];

   function automatic logic [23:0] ref_rgb(input logic [2:0] code);
      case (code)
         3'd2:    return 24'hFFFFFF;
         3'd3:    return 24'hFF0000;
         3'd4:    return 24'h00FF00;
         3'd5:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] ref_pixel(input int x, input int y,
                                             input logic [2:0] cur, input logic [2:0] can);
      if (!(x < W && y < H)) return 24'h000000;
      if (BORDER && (x == 0 || x == W-1 || y == 0 || y == H-1)) return 24'hFFFFFF;
      return (cur != 3'd0) ? ref_rgb(cur) : ref_rgb(can);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (pos %0d,%0d)", name, act, exp, ph, pv);
      end
   endtask

   task automatic drive_colors();
      if (mh < W && mv < H) begin
         cursor_color = cursor_map[mv][mh];
         canvas_color = canvas_map[mv][mh];
      end else begin
         cursor_color = 3'($urandom_range(0, 7));
         canvas_color = 3'($urandom_range(0, 7));
      end
   endtask

   // One clk: apply inputs, advance the model at the edge, compare after it.
   task automatic step(input logic pe, input logic rst);
      bit act;
      pix_en = pe;
      reset  = rst;
      @(posedge clk);
      ph = mh;
      pv = mv;
      e_fs = 1'b0;
      if (rst) begin
         mh = 0; mv = 0;
         e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
      end else if (pe) begin
         act     = (mh < W) && (mv < H);
         e_rgb   = ref_pixel(mh, mv, cursor_color, canvas_color);
         e_hs    = !(mh >= W + 2 && mh < W + 4);
         e_vs    = !(mv >= H + 2 && mv < H + 4);
         e_blank = act;
         if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin
               mv = 0;
               e_fs = 1'b1;
            end else begin
               mv++;
            end
         end else begin
            mh++;
         end
      end
      #1;
      check("rgb",     {vga_r, vga_g, vga_b}, e_rgb);
      check("hs_n",    vga_hs_n, e_hs);
      check("vs_n",    vga_vs_n, e_vs);
      check("blank_n", vga_blank_n, e_blank);
      check("frame_start", frame_start, e_fs);
      check("req_x", req_x, (mh < W && mv < H) ? mh : 0);
      check("req_y", req_y, (mh < W && mv < H) ? mv : 0);
      drive_colors();
   endtask

   int          hs_low, vs_low, fs_cnt;
   logic [23:0] hold_rgb;
   logic        hold_blank;
   bit          reached;
   int          cyc;

   initial begin
      pix_en = 1'b0;
      reset  = 1'b1;
      cursor_color = 3'd0;
      canvas_color = 3'd0;
      mh = 0; mv = 0; ph = 0; pv = 0;

      // Phase 1/2: solid red canvas with one blue cursor pixel at (3,1).
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            canvas_map[y][x] = COLOR_RED;
            cursor_map[y][x] = COLOR_NONE;
         end
      cursor_map[1][3] = COLOR_BLUE;

      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("reset_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
      check("reset_hs_vs", {vga_hs_n, vga_vs_n}, 2'b11);
      check("reset_blank", vga_blank_n, 1'b0);
      check("reset_req", {req_x, req_y}, 5'd0);

      hs_low = 0; vs_low = 0; fs_cnt = 0;
      for (int s = 1; s <= 2 * HT * VT; s++) begin
         step(1'b1, 1'b0);
         if (s <= W) begin
            check("first_line_rgb", {vga_r, vga_g, vga_b}, BORDER ? 24'hFFFFFF : 24'hFF0000);
            check("first_line_blank", vga_blank_n, 1'b1);
         end
         if (s == W + 1) check("first_blank_rgb", {vga_r, vga_g, vga_b, vga_blank_n}, 25'h0);
         if (ph == 3 && pv == 1) check("cursor_pixel", {vga_r, vga_g, vga_b}, 24'h0000FF);
         if ((ph == 2 || ph == 4) && pv == 1)
            check("cursor_neighbour", {vga_r, vga_g, vga_b}, 24'hFF0000);
         if (!vga_hs_n) hs_low++;
         if (!vga_vs_n) vs_low++;
         if (frame_start) fs_cnt++;
      end
      check("hs_low_count", hs_low, 2 * 2 * VT);
      check("vs_low_count", vs_low, 2 * 2 * HT);
      check("frame_start_count", fs_cnt, 2);

      // Phase 3: random layers, strobe every other clk, reset at (5,2).
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            canvas_map[y][x] = 3'($urandom_range(0, 7));
            cursor_map[y][x] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : COLOR_NONE;
         end
      drive_colors();
      reached = 1'b0;
      for (cyc = 0; cyc < 400 && !reached; cyc++) begin
         if (cyc % 2 == 1) begin
            hold_rgb   = {vga_r, vga_g, vga_b};
            hold_blank = vga_blank_n;
            step(1'b0, 1'b0);
            check("hold_rgb", {vga_r, vga_g, vga_b}, hold_rgb);
            check("hold_blank", vga_blank_n, hold_blank);
         end else begin
            step(1'b1, 1'b0);
         end
         if (mh == 5 && mv == 2) reached = 1'b1;
      end
      check("reach_h5v2", reached, 1'b1);
      step(1'b0, 1'b1);
      check("midline_reset_req", {req_x, req_y}, 5'd0);
      check("midline_reset_out", {vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, vga_blank_n, frame_start},
            {24'h0, 1'b1, 1'b1, 1'b0, 1'b0});
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("restart_req", {req_x, req_y}, {3'd1, 2'd0});
      check("restart_blank", vga_blank_n, 1'b1);
      check("restart_no_fs", frame_start, 1'b0);
      for (int s = 0; s < 600; s++) step(1'($urandom_range(0, 1)), 1'b0);

      // Phase 4: green canvas, border behaviour.
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            canvas_map[y][x] = COLOR_GREEN;
            cursor_map[y][x] = COLOR_NONE;
         end
      step(1'b0, 1'b1);
      for (int s = 0; s < HT * VT; s++) begin
         step(1'b1, 1'b0);
         if (pv == 0 && ph < W)
            check("row0", {vga_r, vga_g, vga_b}, BORDER ? 24'hFFFFFF : 24'h00FF00);
         if (ph == W - 1 && pv < H)
            check("col7", {vga_r, vga_g, vga_b}, BORDER ? 24'hFFFFFF : 24'h00FF00);
         if (ph == 3 && pv == 2)
            check("pix_3_2", {vga_r, vga_g, vga_b}, 24'h00FF00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/raster_compositor.md
# raster_compositor

Raster-scan reader for the paint display. Sweeps a VGA-style frame, issues pixel coordinates to the cursor overlay layer and the canvas layer (both single-cycle registered-read stores), and composites the returned color codes, with the cursor winning unless transparent. Maps the result through the shared palette and drives registered RGB, sync and blanking outputs to the DAC.

## Interface
Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch, in pixels
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch, in lines

Ports:
- clk  in  1  system clock
- reset  in  1  reset: synchronous, active-high
- pix_en  in  1  pixel-advance strobe; never asserted on two consecutive clk cycles is NOT required (may be held high)
- req_x  out  $clog2(WIDTH)  column requested from both layers
- req_y  out  $clog2(HEIGHT)  row requested from both layers
- cursor_color  in  COLOR_WIDTH  overlay data for the (req_x, req_y) presented one clk earlier
- canvas_color  in  COLOR_WIDTH  canvas data, same timing as cursor_color
- vga_r / vga_g / vga_b  out  8 each  pixel color
- vga_hs_n / vga_vs_n  out  1 each  syncs, active-low
- vga_blank_n  out  1  high during active video
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

## Operation
- H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP and V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP. h_cnt covers 0..H_TOTAL-1 and v_cnt covers 0..V_TOTAL-1.
- On a clk edge with pix_en=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 and h_cnt = H_TOTAL-1, both wrap to 0 and frame_start pulses on that edge.
- active = (h_cnt < WIDTH) && (v_cnt < HEIGHT).
- req_x and req_y equal h_cnt and v_cnt when active, and 0 otherwise. They are decoded directly from the counter registers.
- Syncs:
  - hs_raw is low while h_cnt is in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC).
  - vs_raw is low while v_cnt is in [HEIGHT+V_FP, HEIGHT+V_FP+V_SYNC).
- Compositing, evaluated at each pix_en edge from the current inputs:
  - If cursor_color != COLOR_NONE, use cursor_color. Otherwise use canvas_color.
  - If not active, force black.
- Palette: NONE→000000, BLACK→000000, WHITE→FFFFFF, RED→FF0000, GREEN→00FF00, BLUE→0000FF. Any other code maps to 000000.
- On each pix_en edge, the output registers capture the palette RGB, hs_raw, vs_raw and active for the counter position that was current before the edge.
- With pix_en=0, all outputs and counters hold. frame_start is the only exception: it is 0 on every cycle except its pulse.

## Timing
- Reset values:
  - h_cnt = v_cnt = 0
  - req_x = req_y = 0
  - vga_r/g/b = 0
  - vga_hs_n = vga_vs_n = 1
  - vga_blank_n = 0
  - frame_start = 0
- Layer read latency is exactly 1 clk. Data for a counter position must be valid at the next pix_en edge, which is always at least 1 clk after the position was set.
- Output latency is 1 pix_en step. The outputs at step n describe the counter position of step n-1. Sync and blank share the color's alignment, so no skew is permitted between them.
- A pix_en held high gives 1 pixel per clk. With pix_en every second clk, outputs change only on the strobe edges.
- Reset asserted mid-line returns everything to its reset values on the next edge. The scan resumes from (0,0) with no partial-frame pulse.
- Simultaneous wrap of h and v produces a single frame_start, not two.

## Configuration
- COMPOSITOR_BORDER_EN:
  - Defined: active pixels with x==0, x==WIDTH-1, y==0 or y==HEIGHT-1 output FFFFFF, overriding both layers.
  - Undefined: no border logic is built, and edge pixels composite normally.

## Structure
- The shared package holds:
  - COLOR_WIDTH and the COLOR_* codes (existing)
  - a new 24-bit RGB palette constant set
  - the color-to-RGB function
- The natural sub-module is vga_timing. It owns the counters, active, hs_raw, vs_raw and frame_start, advances on pix_en, and exposes h_cnt and v_cnt.
- raster_compositor contains the request decode, the compositing mux, the palette and the output registers.

## Test plan
Use WIDTH=8, HEIGHT=4 and all porches/syncs = 2, so H_TOTAL=14 and V_TOTAL=10.
- Reset is held for 2 clk. Required: RGB=0, hs_n=vs_n=1, blank_n=0, req=(0,0).
- pix_en=1, canvas=RED, cursor=NONE. Required: from the first edge, vga = FF0000 with blank_n=1 for 8 pixels, then blank_n=0 and RGB=0.
- cursor=BLUE only at (3,1). Required: that pixel is 0000FF one step after req=(3,1), and neighbours are canvas color.
- Run a full frame. Required:
  - hs_n is low for 2 pixels per line at outputs corresponding to h=10,11.
  - vs_n is low for lines 6,7.
  - frame_start pulses exactly once per 140 steps.
- pix_en toggling every other clk, with reset asserted at h=5, v=2. Required: outputs hold between strobes, and the scan restarts at (0,0) after reset.
- COMPOSITOR_BORDER_EN defined, canvas=GREEN. Required: row 0 and column 7 are FFFFFF, and pixel (3,2) is 00FF00.
